regfile_bank: RTL and testbench
===============================

REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 SHALL have parameter: DATA_W, default 32, width of each register and of every data port.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: wr_en  in  1  write request this cycle.
REQ-005 SHALL have port: wr_addr  in  5  write register index 0..31.
REQ-006 SHALL have port: wr_data  in  DATA_W  write data.
REQ-007 SHALL have port: rd_addr_a  in  5  read port A index.
REQ-008 SHALL have port: rd_addr_b  in  5  read port B index.
REQ-009 SHALL have port: rd_data_a  out  DATA_W  registered read data, port A.
REQ-010 SHALL have port: rd_data_b  out  DATA_W  registered read data, port B.
REQ-011 SHALL have port: clr_req  in  1  start bulk-clear sweep.
REQ-012 SHALL have port: busy  out  1  high while the clear sweep runs.
REQ-013 SHALL have port: wr_rej  out  1  one-cycle pulse: write dropped because busy.

Function
REQ-014 SHALL hold 32 registers of DATA_W bits; the 5-bit index selects one of them as a 32:1 mux would.
REQ-015 SHALL hard-wire register 0 to zero; writes to index 0 have no effect; reads of index 0 return 0.
REQ-016 SHALL, in IDLE with wr_en=1 and wr_addr!=0, load wr_data into register wr_addr at the rising edge.
REQ-017 SHALL register both read ports: rd_data_x after edge N = contents of rd_addr_x sampled at edge N (1-cycle latency).
REQ-018 SHALL let ports A and B address the same or different registers independently; both SHALL be valid every cycle, including during CLEAR.
REQ-019 SHALL implement FSM states IDLE and CLEAR, plus a 5-bit sweep counter.
REQ-020 IDLE -> CLEAR on clr_req=1; counter loads 1; busy=1 from the next cycle.
REQ-021 In CLEAR, each cycle SHALL zero the register at the counter index, then increment the counter; after index 31 is zeroed, return to IDLE (31 CLEAR cycles); busy=0 from the next cycle.
REQ-022 SHALL ignore clr_req while in CLEAR (no restart, no extension).
REQ-023 SHALL drop any wr_en=1 that arrives while in CLEAR and pulse wr_rej=1 for that cycle (registered, visible the next cycle); wr_rej=0 otherwise.
REQ-024 If clr_req=1 and wr_en=1 arrive in the same IDLE cycle, SHALL perform the write, then enter CLEAR; the sweep later zeroes that register.
REQ-025 Reads in CLEAR SHALL return current contents: already-swept indices read 0, the rest hold prior values.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, zero all 32 registers, rd_data_a, rd_data_b, wr_rej, busy, and the counter, and force state to IDLE.
REQ-027 Reset asserted mid-sweep SHALL abort CLEAR; after release the block SHALL be in IDLE and accept writes on the first edge.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN defined: when wr_en performs a write (REQ-016) at edge N and rd_addr_x==wr_addr!=0 at the same edge, rd_data_x SHALL take wr_data.
REQ-029 Macro REGFILE_BYPASS_EN undefined: in that case rd_data_x SHALL take the pre-write register value; the new value appears one read later.
REQ-030 Bypass SHALL never apply to index 0, to rejected writes, or to the sweep's zero writes.

Verification
REQ-031 After reset, write 0xDEADBEEF to r5, then read r5 on A -> rd_data_a=0xDEADBEEF one cycle after the read address is presented.
REQ-032 Write 0x12345678 to r0, read r0 on A and B -> both read 0x00000000.
REQ-033 r7=0x11111111, write 0x22222222 to r7 while rd_addr_a=7 in the same cycle -> with REGFILE_BYPASS_EN rd_data_a=0x22222222, without it 0x11111111.
REQ-034 Fill r1..r31 with their index, pulse clr_req, then wr_en to r3 at sweep cycle 5 -> busy high for exactly 31 cycles; wr_rej pulses once; all registers read 0 afterwards.
REQ-035 Assert rst_n=0 asynchronously at sweep cycle 10 -> busy, rd_data_a/b and all registers become 0 immediately; first write after release succeeds.

Source files
------------

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - 32-entry register file with two registered read ports and a bulk-clear sweep
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_bank #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_rej
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [4:0]        cnt, cnt_nxt;
    logic              wr_we, clr_we, rej_nxt;
    logic [DATA_W-1:0] regs [32];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_we     = 1'b0;
        clr_we    = 1'b0;
        rej_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // A same-cycle write still lands; the sweep zeroes it later.
                wr_we = wr_en && (wr_addr != 5'd0);
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = 5'd1;
                end
            end
            CLEAR: begin
                clr_we  = 1'b1;
                rej_nxt = wr_en;
                cnt_nxt = cnt + 5'd1;
                if (cnt == 5'd31) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            wr_rej <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            wr_rej <= rej_nxt;
        end
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_we) begin
            regs[wr_addr] <= wr_data;
        end else if (clr_we) begin
            regs[cnt] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
`ifdef REGFILE_BYPASS_EN
            rd_data_a <= (wr_we && rd_addr_a == wr_addr) ? wr_data : regs[rd_addr_a];
            rd_data_b <= (wr_we && rd_addr_b == wr_addr) ? wr_data : regs[rd_addr_b];
`else
            rd_data_a <= regs[rd_addr_a];
            rd_data_b <= regs[rd_addr_b];
`endif
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_regfile_bank.sv
// tb/tb_regfile_bank.sv - randomized self-checking bench for regfile_bank against a behavioural model
module tb_regfile_bank;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_addr_a = '0;
    logic [4:0]  rd_addr_b = '0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        clr_req = 1'b0;
    logic        busy, wr_rej;

    regfile_bank #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .clr_req(clr_req), .busy(busy), .wr_rej(wr_rej)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: register contents, plus the number of sweep cycles still to run
    // and which index the next one zeroes.
    logic [31:0] mdl [32];
    int          sweep_left = 0;
    int          sweep_idx  = 0;
    logic [31:0] exp_a = 0, exp_b = 0;
    logic        exp_rej = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        sweep_left = 0;
        sweep_idx  = 0;
        exp_a = 0; exp_b = 0; exp_rej = 0;
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, check them #1 after the edge.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb, input logic clr);
        logic writes;
        wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb; clr_req = clr;
        @(posedge clk);
        writes = (sweep_left == 0) && we && (wa != 5'd0);
        exp_a = (BYP && writes && ra == wa) ? wd : mdl[ra];
        exp_b = (BYP && writes && rb == wa) ? wd : mdl[rb];
        if (sweep_left == 0) begin
            exp_rej = 1'b0;
            if (writes) mdl[wa] = wd;
            if (clr) begin
                sweep_left = 31;
                sweep_idx  = 1;
            end
        end else begin
            exp_rej = we;
            mdl[sweep_idx] = 32'd0;
            sweep_idx++;
            sweep_left--;
        end
        #1;
        check("rd_data_a", rd_data_a, exp_a);
        check("rd_data_b", rd_data_b, exp_b);
        check("busy", {31'd0, busy}, {31'd0, sweep_left != 0});
        check("wr_rej", {31'd0, wr_rej}, {31'd0, exp_rej});
    endtask

    task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
        step(1'b0, 5'd0, 32'd0, ra, rb, 1'b0);
    endtask

    int busy_cycles;
    int rej_pulses;

    initial begin
        mdl_reset();
        #3;
        check("reset rd_data_a", rd_data_a, 32'd0);
        check("reset rd_data_b", rd_data_b, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset wr_rej", {31'd0, wr_rej}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write r5 then read it back.
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
        idle_read(5'd5, 5'd5);
        check("r5 readback", rd_data_a, 32'hDEADBEEF);

        // r0 is hard-wired to zero.
        step(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0);
        idle_read(5'd0, 5'd0);
        check("r0 port a", rd_data_a, 32'd0);
        check("r0 port b", rd_data_b, 32'd0);

        // Same-cycle write/read of r7.
        step(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd0, 1'b0);
        check("r7 same-cycle", rd_data_a, BYP ? 32'h22222222 : 32'h11111111);
        idle_read(5'd7, 5'd7);
        check("r7 after", rd_data_a, 32'h22222222);

        // Fill, sweep, rejected write at sweep cycle 5.
        for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'(i), 5'(i - 1), 5'(i), 1'b0);
        step(1'b0, 5'd0, 32'd0, 5'd3, 5'd31, 1'b1);
        busy_cycles = 0;
        rej_pulses  = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_cycles++;
            step(c == 5, 5'd3, 32'hBAD0BAD0, 5'(c % 32), 5'(31 - (c % 32)), 1'b0);
            if (wr_rej) rej_pulses++;
        end
        check("sweep busy cycles", busy_cycles, 32'd31);
        check("sweep wr_rej pulses", rej_pulses, 32'd1);
        for (int i = 0; i < 32; i += 2) begin
            idle_read(5'(i), 5'(i + 1));
            check("post-sweep a", rd_data_a, 32'd0);
            check("post-sweep b", rd_data_b, 32'd0);
        end

        // Asynchronous reset at sweep cycle 10.
        for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'hA5000000 | 32'(i), 5'd0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 5'd20, 5'd30, 1'b1);
        for (int c = 1; c < 10; c++) step(1'b0, 5'd0, 32'd0, 5'd20, 5'd30, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst rd_data_a", rd_data_a, 32'd0);
        check("async rst rd_data_b", rd_data_b, 32'd0);
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5'd9, 32'hCAFEF00D, 5'd20, 5'd30, 1'b0);
        idle_read(5'd9, 5'd25);
        check("write after reset", rd_data_a, 32'hCAFEF00D);
        check("reg cleared by reset", rd_data_b, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
